fetch_queue_unit: RTL and testbench

Parametrised next-generation instruction fetch stage. Fetches from a direct-mapped i-cache or the memory controller, redirects on JAL and predicted-taken branches, and buffers fetched instructions in a QUEUE_DEPTH-entry FIFO. The decoder consumes the FIFO through a valid/ready handshake. Sits between the memory controller, the branch predictor, the decoder and the ROB (misbranch flush).

---
 rtl/fetch_queue_unit_if.sv | 45 ++++
 rtl/fetch_queue_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if
//   Bundles every non-clock signal of the fetch stage. clk, rst and rdy stay
//   as plain ports on the unit.
//   master : the fetch unit (drives out_*, samples in_*)
//   slave  : the environment (memory controller, decoder, ROB, predictor)
//   Memory side   : out_mem_ce/out_mem_pc request, in_mem_ce/in_mem_instr reply
//   Decoder side  : out_valid/out_instr/out_pc/out_jump_ce, in_dec_ready,
//                   out_queue_count
//   ROB side      : in_rob_misbranch, in_rob_newpc
//   Predictor     : out_bp_tag -> in_bp_jump_ce (same-cycle lookup)
interface fetch_queue_unit_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int BP_TAG_BITS = 8
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                   out_mem_ce;
  logic [31:0]            out_mem_pc;
  logic                   in_mem_ce;
  logic [31:0]            in_mem_instr;
  logic                   out_valid;
  logic [31:0]            out_instr;
  logic [31:0]            out_pc;
  logic                   out_jump_ce;
  logic                   in_dec_ready;
  logic [CNT_W-1:0]       out_queue_count;
  logic                   in_rob_misbranch;
  logic [31:0]            in_rob_newpc;
  logic [BP_TAG_BITS-1:0] out_bp_tag;
  logic                   in_bp_jump_ce;

  modport master (
    output out_mem_ce, out_mem_pc, out_valid, out_instr, out_pc, out_jump_ce,
           out_queue_count, out_bp_tag,
    input  in_mem_ce, in_mem_instr, in_dec_ready, in_rob_misbranch,
           in_rob_newpc, in_bp_jump_ce
  );

  modport slave (
    input  out_mem_ce, out_mem_pc, out_valid, out_instr, out_pc, out_jump_ce,
           out_queue_count, out_bp_tag,
    output in_mem_ce, in_mem_instr, in_dec_ready, in_rob_misbranch,
           in_rob_newpc, in_bp_jump_ce
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch stage. Looks the current pc up in a direct-mapped,
//   one-word-per-line i-cache; on a miss it issues a one-cycle request to the
//   memory controller and waits for the reply. Every fetched instruction is
//   pushed into a QUEUE_DEPTH-entry FIFO together with its pc and a
//   predicted-taken flag; the decoder drains the FIFO with valid/ready.
//   JAL and predicted-taken branches redirect the fetch pc immediately.
//   A ROB misbranch empties the FIFO and restarts fetch at in_rob_newpc; a
//   reply still in flight at that point is swallowed in DISCARD.
//
//   Ports: clk, rst (async, active low), rdy (global enable, low = freeze),
//          bus (fetch_queue_unit_if.master, see interface header).
//
//   Build option: FETCH_ICACHE_EN -- when defined the i-cache is present;
//   when undefined there is no cache storage and every fetch goes to memory.
module fetch_queue_unit #(
  parameter int ICACHE_LINES = 128,
  parameter int QUEUE_DEPTH  = 4,
  parameter int BP_TAG_BITS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  fetch_queue_unit_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DISCARD} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        jump;
  } entry_t;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             mem_ce_q, mem_ce_d;
  logic [31:0]      mem_pc_q, mem_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           fifo_q [QUEUE_DEPTH];

  logic             hit;
  logic [31:0]      line_instr;
  logic [31:0]      push_instr;
  logic             push_jump;
  logic [31:0]      next_pc;
  logic [31:0]      jal_off, br_off;
  logic             push, pop, full, valid;

  assign full  = (cnt_q == FULL_CNT);
  assign valid = (cnt_q != '0);

  // --------------------------------------------------------------------------
  // i-cache: valid bits are reset, tag/data arrays are not (valid gates them)
  // --------------------------------------------------------------------------
`ifdef FETCH_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] cvld_q;
  logic [TAG_W-1:0]        ctag_q [ICACHE_LINES];
  logic [31:0]             cdat_q [ICACHE_LINES];
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    cache_we;

  assign idx        = pc_q[IDX_W+1:2];
  assign tag        = pc_q[31:IDX_W+2];
  assign hit        = cvld_q[idx] && (ctag_q[idx] == tag);
  assign line_instr = cdat_q[idx];
  // Only a reply taken in WAIT_MEM fills a line; DISCARD replies never do.
  assign cache_we   = push && (state_q == WAIT_MEM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cvld_q      <= '0;
    else if (rdy && cache_we)  cvld_q[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rdy && cache_we) begin
      ctag_q[idx] <= tag;
      cdat_q[idx] <= bus.in_mem_instr;
    end
  end
`else
  assign hit        = 1'b0;
  assign line_instr = '0;
`endif

  // --------------------------------------------------------------------------
  // Redirect decode of the instruction being pushed. The instruction always
  // belongs to pc_q (pc does not move while waiting on memory), so the
  // predictor lookup on out_bp_tag lines up with it.
  // --------------------------------------------------------------------------
  always_comb begin
    push_instr = (state_q == IDLE) ? line_instr : bus.in_mem_instr;
    jal_off    = {{11{push_instr[31]}}, push_instr[31], push_instr[19:12],
                  push_instr[20], push_instr[30:21], 1'b0};
    br_off     = {{19{push_instr[31]}}, push_instr[31], push_instr[7],
                  push_instr[30:25], push_instr[11:8], 1'b0};
    push_jump  = 1'b0;
    next_pc    = pc_q + 32'd4;
    if (push_instr[6:0] == 7'b1101111) begin
      next_pc = pc_q + jal_off;
    end else if (push_instr[6:0] == 7'b1100011 && bus.in_bp_jump_ce) begin
      next_pc   = pc_q + br_off;
      push_jump = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM + FIFO pointer next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_ce_d = 1'b0;
    mem_pc_d = mem_pc_q;
    push     = 1'b0;

    if (bus.in_rob_misbranch) begin
      pc_d = bus.in_rob_newpc;
      // An outstanding reply must still be absorbed before fetching again.
      state_d = (state_q == IDLE) ? IDLE : DISCARD;
    end else begin
      case (state_q)
        IDLE: begin
          if (!full) begin
            if (hit) begin
              push = 1'b1;
              pc_d = next_pc;
            end else begin
              mem_ce_d = 1'b1;
              mem_pc_d = pc_q;
              state_d  = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // Slot is free: the request was only issued with the FIFO not full.
          if (bus.in_mem_ce) begin
            push    = 1'b1;
            pc_d    = next_pc;
            state_d = IDLE;
          end
        end
        DISCARD: begin
          if (bus.in_mem_ce) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    pop    = valid && bus.in_dec_ready && !bus.in_rob_misbranch;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (bus.in_rob_misbranch) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      mem_ce_q <= 1'b0;
      mem_pc_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mem_ce_q <= mem_ce_d;
      mem_pc_q <= mem_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && push && !bus.in_rob_misbranch)
      fifo_q[tail_q] <= '{instr: push_instr, pc: pc_q, jump: push_jump};
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.out_mem_ce      = mem_ce_q;
  assign bus.out_mem_pc      = mem_pc_q;
  assign bus.out_valid       = valid;
  assign bus.out_instr       = fifo_q[head_q].instr;
  assign bus.out_pc          = fifo_q[head_q].pc;
  assign bus.out_jump_ce     = fifo_q[head_q].jump;
  assign bus.out_queue_count = cnt_q;
  assign bus.out_bp_tag      = pc_q[BP_TAG_BITS+1:2];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//   Randomized bench for fetch_queue_unit. The program image is a 64-word
//   table (addr[7:2]) with the redirect offset of every word kept beside its
//   encoding; the reference model walks that table to produce the expected
//   instruction stream and compares it with everything the decoder pops.
//   The memory responder, decoder and ROB are modelled in one cycle task.
module tb_fetch_queue_unit;
  localparam int QD    = 4;
  localparam int LINES = 128;
  localparam int BPW   = 8;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.QUEUE_DEPTH(QD), .BP_TAG_BITS(BPW)) bus ();

  fetch_queue_unit #(.ICACHE_LINES(LINES), .QUEUE_DEPTH(QD), .BP_TAG_BITS(BPW)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- program image ----------------
  logic [31:0] img      [64];
  int          img_kind [64];   // 0 plain, 1 jal, 2 branch
  int          img_off  [64];

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 5'd0, 5'd0, 3'd0, im[4:1], im[11], 7'b1100011};
  endfunction

  // ---------------- predictor ----------------
  bit bp_all = 1'b1;
  function automatic logic pred(input logic [31:0] pc);
    return bp_all ? 1'b1 : ^(pc[BPW+1:2] & 8'h2D);
  endfunction
  always_comb bus.in_bp_jump_ce = bp_all ? 1'b1 : ^(bus.out_bp_tag & 8'h2D);

  // ---------------- reference model ----------------
  logic [31:0] exp_pc;
  int          npop = 0;
  logic        cvalid [LINES];
  logic [31:0] caddr  [LINES];

  function automatic logic cached(input logic [31:0] a);
    return cvalid[a[8:2]] && (caddr[a[8:2]] == a);
  endfunction

  task automatic model_pop();
    int   k;
    logic j;
    k = int'(exp_pc[7:2]);
    j = (img_kind[k] == 2) && pred(exp_pc);
    chk("head_pc",    bus.out_pc, exp_pc);
    chk("head_instr", bus.out_instr, img[k]);
    chk("head_jump",  32'(bus.out_jump_ce), 32'(j));
    if (img_kind[k] == 1 || j) exp_pc = exp_pc + 32'(img_off[k]);
    else                       exp_pc = exp_pc + 32'd4;
    npop++;
  endtask

  // ---------------- environment state / knobs ----------------
  int p_rdy = 100, p_ready = 100, p_mis = 0, lat_min = 2, lat_max = 2;
  int force_mis = 0;            // 1: misbranch while a request is out, 2: at once
  logic [31:0] force_pc;
  bit pend, dirty, chk_req;
  logic [31:0] req_pc, chk_req_pc;
  int lat;
  int exp_cnt_next = -1;
  logic [31:0] reqlog [$];

  task automatic model_reset();
    exp_pc = '0; pend = 0; dirty = 0; exp_cnt_next = -1;
    chk_req = 1; chk_req_pc = '0;
    for (int i = 0; i < LINES; i++) cvalid[i] = 1'b0;
  endtask

  task automatic hold_inputs_idle();
    bus.in_mem_ce = 0; bus.in_mem_instr = '0; bus.in_dec_ready = 0;
    bus.in_rob_misbranch = 0; bus.in_rob_newpc = '0;
  endtask

  task automatic do_reset(input bit bp_mode);
    rst = 1'b0; rdy = 1'b1;
    hold_inputs_idle();
    bp_all = bp_mode;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: observe after the edge, drive, then account at the negedge.
  task automatic step();
    bit deliver, mis;
    logic [31:0] npc;
    @(posedge clk); #1;
    if (exp_cnt_next >= 0) begin
      chk("count_after", 32'(bus.out_queue_count), 32'(exp_cnt_next));
      exp_cnt_next = -1;
    end
    if (bus.out_mem_ce && !pend) begin
      pend = 1; dirty = 0; req_pc = bus.out_mem_pc; reqlog.push_back(req_pc);
      lat = int'($urandom_range(lat_max, lat_min));
`ifdef FETCH_ICACHE_EN
      chk("req_not_cached", 32'(cached(req_pc)), 32'd0);
`endif
      if (chk_req) begin
        chk("req_pc", req_pc, chk_req_pc);
        chk_req = 0;
      end
    end
    rdy              = ($urandom_range(99) < p_rdy);
    bus.in_dec_ready = ($urandom_range(99) < p_ready);
    deliver          = pend && rdy && (lat == 0);
    bus.in_mem_ce    = deliver;
    bus.in_mem_instr = deliver ? img[req_pc[7:2]] : $urandom;
    mis = 0; npc = '0;
    if (rdy && !deliver) begin
      if (force_mis == 2 || (force_mis == 1 && pend)) begin
        mis = 1; npc = force_pc; force_mis = 0;
        chk_req = 1; chk_req_pc = npc;
      end else if ($urandom_range(999) < p_mis) begin
        mis = 1; npc = {20'd0, 10'($urandom_range(1023)), 2'b00};
`ifndef FETCH_ICACHE_EN
        chk_req = 1; chk_req_pc = npc;
`endif
      end
    end
    bus.in_rob_misbranch = mis;
    bus.in_rob_newpc     = npc;
    if (pend && rdy && lat > 0) lat--;
    @(negedge clk);
    if (mis) begin
      exp_pc = npc; exp_cnt_next = 0;
      if (pend) dirty = 1;
    end else if (rdy && bus.out_valid && bus.in_dec_ready) begin
      model_pop();
    end
    if (deliver) begin
      pend = 0;
`ifdef FETCH_ICACHE_EN
      if (!dirty) begin
        cvalid[req_pc[8:2]] = 1'b1;
        caddr[req_pc[8:2]]  = req_pc;
      end
`endif
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int snap_req, snap_pop, waited;
    logic [31:0] r;

    for (int k = 0; k < 64; k++) begin
      img[k] = 32'h0000_0013; img_kind[k] = 0; img_off[k] = 0;
    end
    img[4] = enc_jal(8);  img_kind[4] = 1; img_off[4] = 8;    // pc 0x10
    img[8] = enc_br(-4);  img_kind[8] = 2; img_off[8] = -4;   // pc 0x20

    // reset state
    rst = 1'b1; rdy = 1'b1;
    hold_inputs_idle();
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_ce", 32'(bus.out_mem_ce), 32'd0);
    chk("rst_mem_pc", bus.out_mem_pc, 32'd0);
    chk("rst_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_count",  32'(bus.out_queue_count), 32'd0);
    do_reset(1'b1);

    // cold start + straight line, JAL and taken BEQ
    run(60);
    chk("cold_req_seen", 32'(reqlog.size() >= 2), 32'd1);
    if (reqlog.size() >= 2) begin
      chk("cold_req0", reqlog[0], 32'h0);
      chk("cold_req1", reqlog[1], 32'h4);
    end
    chk("cold_pops", 32'(npop >= 8), 32'd1);

`ifdef FETCH_ICACHE_EN
    // loop now runs from the cache: no memory traffic, one pop per cycle
    snap_req = reqlog.size(); snap_pop = npop;
    run(30);
    chk("loop_no_req", 32'(reqlog.size()), 32'(snap_req));
    chk("loop_rate", 32'(npop - snap_pop >= 25), 32'd1);
`endif

    // decoder stalled: FIFO fills to QD and fetching stops
    p_ready = 0;
    run(40);
    chk("full_count", 32'(bus.out_queue_count), 32'(QD));
    snap_req = reqlog.size();
    run(10);
    chk("full_no_req", 32'(reqlog.size()), 32'(snap_req));
    p_ready = 100;
    step();
    exp_cnt_next = QD - 1;
    run(20);

    // misbranch while waiting on memory
    force_pc = 32'h200; force_mis = 2;
    run(4);
    lat_min = 4; lat_max = 4;
    force_pc = 32'h100; force_mis = 1;
    run(40);
    chk("forced_mis_fired", 32'(force_mis), 32'd0);

    // async reset in the middle of WAIT_MEM
    lat_min = 6; lat_max = 6;
    force_pc = 32'h300; force_mis = 2;
    waited = 0;
    do begin step(); waited++; end while (!(force_mis == 0 && pend) && waited < 30);
    chk("wait_mem_reached", 32'(force_mis == 0 && pend), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_mem_ce", 32'(bus.out_mem_ce), 32'd0);
    chk("arst_mem_pc", bus.out_mem_pc, 32'd0);
    chk("arst_valid",  32'(bus.out_valid), 32'd0);
    chk("arst_count",  32'(bus.out_queue_count), 32'd0);
    lat_min = 2; lat_max = 2;
    do_reset(1'b1);
    run(40);

    // randomized program, predictor, stalls, freezes and misbranches
    for (int k = 0; k < 64; k++) begin
      r = $urandom;
      case ($urandom_range(99) / 15)
        0: begin img_kind[k] = 1; img_off[k] = (int'($urandom_range(16)) - 8) * 4;
                 img[k] = enc_jal(img_off[k]); end
        1: begin img_kind[k] = 2; img_off[k] = (int'($urandom_range(16)) - 8) * 4;
                 img[k] = enc_br(img_off[k]); end
        default: begin img_kind[k] = 0; img_off[k] = 0; img[k] = {r[31:7], 7'b0010011}; end
      endcase
    end
    p_rdy = 85; p_ready = 60; p_mis = 15; lat_min = 0; lat_max = 4;
    do_reset(1'b0);
    snap_pop = npop;
    run(3000);
    chk("random_progress", 32'(npop - snap_pop > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
